// File: rtl/sif_xw_bridge.sv
// sif_xw_bridge: X-agent to W-agent write bridge.
// X writes update a shadow register file and are queued in a small FIFO;
// the FIFO head is presented show-ahead on the W port and popped on
// wa_wr_s && wa_ready. X reads return shadow contents one cycle later.
module sif_xw_bridge #(
  parameter int DW     = 16,
  parameter int DEPTH  = 4,
  parameter int REG_AW = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         xa_wr_s,
  input  logic                         xa_rd_s,
  input  logic [DW-1:0]                xa_addr,
  input  logic [DW-1:0]                xa_data_wr,
  output logic [DW-1:0]                xa_data_rd,
  output logic                         xa_full,
  input  logic                         wa_ready,
  output logic                         wa_wr_s,
  output logic [DW-1:0]                wa_addr,
  output logic [DW-1:0]                wa_data_wr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         ovf_sticky
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int NREG = 2**REG_AW;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t              state;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [2*DW-1:0]     mem [DEPTH];
  logic [DW-1:0]       shadow [NREG];

  logic                pop;
  logic                push;
  logic                drop;
  logic [REG_AW-1:0]   idx;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop  = wa_wr_s && wa_ready;
  assign push = xa_wr_s && (!xa_full || pop);
  assign drop = xa_wr_s && !push;
  assign idx  = xa_addr[REG_AW-1:0];

  // Head is read straight out of the storage array; it only moves on a pop,
  // so it holds steady while the sink stalls.
  assign {wa_addr, wa_data_wr} = mem[rd_ptr];

  // Occupancy FSM: pointers, level and the registered full/valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wa_wr_s    <= 1'b0;
      xa_full    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (drop) ovf_sticky <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state   <= ST_ACTIVE;
            wa_wr_s <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (push && !pop && fifo_level == LW'(DEPTH-1)) begin
            state   <= ST_FULL;
            xa_full <= 1'b1;
          end else if (pop && !push && fifo_level == LW'(1)) begin
            state   <= ST_EMPTY;
            wa_wr_s <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop && !push) begin
            state   <= ST_ACTIVE;
            xa_full <= 1'b0;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          wa_wr_s <= 1'b0;
          xa_full <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: data only, queued entries are discarded by pointer reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {xa_addr, xa_data_wr};
  end

  // Shadow register file, written only by accepted X writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (push) begin
      shadow[idx] <= xa_data_wr;
    end
  end

  // Registered X read port, write-first against an accepted same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      xa_data_rd <= '0;
    end else if (xa_rd_s) begin
      xa_data_rd <= push ? xa_data_wr : shadow[idx];
    end
  end

endmodule
